// File: rtl/vga_fb_pkg.sv
// Shared constants and helpers for the VGA framebuffer arbiter.
// Geometry is fixed for the 800x480, 3 bpp packed-pixel framebuffer.
package vga_fb_pkg;

    localparam int LINES      = 480;
    localparam int LINE_WORDS = 100;
    localparam int DATA_W     = 24;
    localparam int ADDR_W     = 16;
    localparam int LB_AW      = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic logic [ADDR_W-1:0] line_base(input logic [8:0] ln);
        return ADDR_W'(ln) * ADDR_W'(LINE_WORDS);
    endfunction

endpackage

// File: rtl/vga_fb_rd_pipe.sv
// Read-return tracker: MEM_LAT-deep shift of {valid, idx} that turns
// issued RAM reads into line buffer writes, with synchronous flush.
module vga_fb_rd_pipe
    import vga_fb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             issue_i,
    input  logic [LB_AW-1:0] idx_i,
    output logic             lb_we_o,
    output logic [LB_AW-1:0] lb_addr_o,
    output logic             pending_o
);

    logic [MEM_LAT-1:0] vld_q;
    logic [LB_AW-1:0]   idx_q [MEM_LAT];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            vld_q <= '0;
            for (int k = 0; k < MEM_LAT; k++) begin
                idx_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= issue_i;
            idx_q[0] <= idx_i;
            for (int k = 1; k < MEM_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                idx_q[k] <= idx_q[k-1];
            end
        end
    end

    // Reads still in flight after the one retiring this cycle.
    always_comb begin
        pending_o = 1'b0;
        for (int k = 0; k < MEM_LAT - 1; k++) begin
            pending_o = pending_o | vld_q[k];
        end
    end

    assign lb_we_o   = vld_q[MEM_LAT-1];
    assign lb_addr_o = lb_we_o ? idx_q[MEM_LAT-1] : '0;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: scanline prefetch has priority, writer fills gaps.
// Define VGA_FB_ARB_WR_SLOT_EN to give the writer periodic slots during fetch.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int MEM_LAT = 1
`ifdef VGA_FB_ARB_WR_SLOT_EN
    ,
    parameter int WR_SLOT_PERIOD = 8
`endif
) (
    input  logic              CLOCK_PIXEL,
    input  logic              RESET,
    input  logic              line_req,
    input  logic [8:0]        line_num,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [LB_AW-1:0]  lb_addr,
    output logic [DATA_W-1:0] lb_data,
    output logic              fetch_busy,
    output logic              underrun,
    input  logic              underrun_clr
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LB_AW-1:0]  idx_q, idx_d;
    logic              underrun_q, underrun_d;
    logic              line_ok, busy, rd_issue, slot_take, pending;

    assign line_ok = line_req && (line_num < 9'(LINES));
    assign busy    = (state_q != ST_IDLE);

`ifdef VGA_FB_ARB_WR_SLOT_EN
    localparam int CW = (WR_SLOT_PERIOD > 1) ? $clog2(WR_SLOT_PERIOD) : 1;
    logic [CW-1:0] cnt_q, cnt_d;

    assign slot_take = (state_q == ST_FETCH) && wr_req &&
                       (cnt_q == CW'(WR_SLOT_PERIOD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (line_ok) begin
            cnt_d = '0;
        end else if (state_q == ST_FETCH) begin
            cnt_d = (cnt_q == CW'(WR_SLOT_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_PIXEL) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign slot_take = 1'b0;
`endif

    // A restarting request burns its cycle so the old line never issues again.
    assign rd_issue = (state_q == ST_FETCH) && !line_ok && !slot_take;
    assign wr_gnt   = wr_req && !rd_issue;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        underrun_d = underrun_q;
        if (underrun_clr) underrun_d = 1'b0;
        if (line_ok) begin
            base_d  = line_base(line_num);
            idx_d   = '0;
            state_d = ST_FETCH;
            if (busy) underrun_d = 1'b1;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (rd_issue) begin
                        idx_d = idx_q + 1'b1;
                        if (idx_q == LB_AW'(LINE_WORDS - 1)) state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: if (!pending) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_PIXEL) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            idx_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            underrun_q <= underrun_d;
        end
    end

    vga_fb_rd_pipe #(.MEM_LAT(MEM_LAT)) u_rd_pipe (
        .clk_i     (CLOCK_PIXEL),
        .rst_i     (RESET),
        .flush_i   (line_ok && busy),
        .issue_i   (rd_issue),
        .idx_i     (idx_q),
        .lb_we_o   (lb_we),
        .lb_addr_o (lb_addr),
        .pending_o (pending)
    );

    assign mem_re     = rd_issue;
    assign mem_we     = wr_gnt;
    assign mem_addr   = rd_issue ? base_q + ADDR_W'(idx_q) :
                        wr_gnt   ? wr_addr : '0;
    assign mem_wdata  = wr_gnt ? wr_data : '0;
    assign lb_data    = lb_we ? mem_rdata : '0;
    assign fetch_busy = busy;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter at MEM_LAT = 1.
// Runs the writer-slot scenario when VGA_FB_ARB_WR_SLOT_EN is defined.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        RESET;
    logic        line_req;
    logic [8:0]  line_num;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [23:0] wr_data;
    logic        wr_gnt;
    logic [15:0] mem_addr;
    logic [23:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [23:0] mem_rdata;
    logic        lb_we;
    logic [6:0]  lb_addr;
    logic [23:0] lb_data;
    logic        fetch_busy;
    logic        underrun;
    logic        underrun_clr;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .CLOCK_PIXEL  (clk),
        .RESET        (RESET),
        .line_req     (line_req),
        .line_num     (line_num),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_gnt       (wr_gnt),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .lb_we        (lb_we),
        .lb_addr      (lb_addr),
        .lb_data      (lb_data),
        .fetch_busy   (fetch_busy),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    function automatic logic [23:0] pat(input logic [15:0] a);
        return {8'hA5, a};
    endfunction

    // One-cycle-latency RAM returning a pattern derived from the address.
    always @(posedge clk) begin
        mem_rdata <= mem_re ? pat(mem_addr) : 24'h0;
    end

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({wr_gnt, mem_addr, mem_wdata, mem_we, mem_re, lb_we, lb_addr,
             lb_data, fetch_busy, underrun} !== '0) begin
            errs++;
            $display("FAIL reset_in got gnt=%b re=%b we=%b lbwe=%b busy=%b ur=%b exp all 0",
                     wr_gnt, mem_re, mem_we, lb_we, fetch_busy, underrun);
        end
        @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({mem_re, mem_we, lb_we, fetch_busy, underrun} !== 5'b0) begin
            errs++;
            $display("FAIL reset_out got re=%b we=%b lbwe=%b busy=%b ur=%b exp 0",
                     mem_re, mem_we, lb_we, fetch_busy, underrun);
        end
    endtask

    task automatic test_fetch(input logic [8:0] ln);
        logic [15:0] b, ea;
        logic        eb, er, el;
        logic [6:0]  ei;
        logic [23:0] ed;
        b = 16'(ln) * 16'd100;
        for (int c = 0; c <= 103; c++) begin
            @(negedge clk);
            line_req = (c == 0);
            line_num = ln;
            #1;
            eb = (c >= 1 && c <= 101);
            er = (c >= 1 && c <= 100);
            ea = er ? b + 16'(c - 1) : 16'h0;
            el = (c >= 2 && c <= 101);
            ei = el ? 7'(c - 2) : 7'h0;
            ed = el ? pat(b + 16'(c - 2)) : 24'h0;
            checks++;
            if ({fetch_busy, mem_re, mem_we, mem_addr} !== {eb, er, 1'b0, ea}) begin
                errs++;
                $display("FAIL fetch_rd line=%0d c=%0d got busy=%b re=%b we=%b addr=%h exp busy=%b re=%b we=0 addr=%h",
                         ln, c, fetch_busy, mem_re, mem_we, mem_addr, eb, er, ea);
            end
            checks++;
            if ({lb_we, lb_addr, lb_data} !== {el, ei, ed}) begin
                errs++;
                $display("FAIL fetch_lb line=%0d c=%0d got we=%b a=%0d d=%h exp we=%b a=%0d d=%h",
                         ln, c, lb_we, lb_addr, lb_data, el, ei, ed);
            end
        end
    endtask

    task automatic test_bad_line();
        logic [15:0] ea;
        logic        er;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            line_req = (c == 0);
            line_num = 9'd480;
            #1;
            checks++;
            if ({mem_re, fetch_busy, underrun} !== 3'b0) begin
                errs++;
                $display("FAIL bad_idle c=%0d got re=%b busy=%b ur=%b exp 0",
                         c, mem_re, fetch_busy, underrun);
            end
        end
        for (int c = 0; c <= 103; c++) begin
            @(negedge clk);
            line_req = (c == 0) || (c == 10);
            line_num = (c == 10) ? 9'd480 : 9'd1;
            #1;
            er = (c >= 1 && c <= 100);
            ea = er ? 16'd100 + 16'(c - 1) : 16'h0;
            checks++;
            if ({mem_re, mem_addr, underrun} !== {er, ea, 1'b0}) begin
                errs++;
                $display("FAIL bad_busy c=%0d got re=%b addr=%h ur=%b exp re=%b addr=%h ur=0",
                         c, mem_re, mem_addr, underrun, er, ea);
            end
        end
        line_req = 1'b0;
    endtask

    task automatic test_same_cycle();
        int n;
        @(negedge clk);
        line_req = 1'b1;
        line_num = 9'd7;
        wr_req   = 1'b1;
        wr_addr  = 16'h0042;
        wr_data  = 24'h123456;
        #1;
        checks++;
        if ({wr_gnt, mem_we, mem_re, mem_addr, mem_wdata} !==
            {1'b1, 1'b1, 1'b0, 16'h0042, 24'h123456}) begin
            errs++;
            $display("FAIL same_wr got gnt=%b we=%b re=%b addr=%h wd=%h exp 1 1 0 0042 123456",
                     wr_gnt, mem_we, mem_re, mem_addr, mem_wdata);
        end
        @(negedge clk);
        line_req = 1'b0;
        wr_req   = 1'b0;
        #1;
        checks++;
        if ({mem_re, mem_we, mem_addr} !== {1'b1, 1'b0, 16'd700}) begin
            errs++;
            $display("FAIL same_rd got re=%b we=%b addr=%0d exp re=1 we=0 addr=700",
                     mem_re, mem_we, mem_addr);
        end
        n = 0;
        while (fetch_busy && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (fetch_busy !== 1'b0) begin
            errs++;
            $display("FAIL same_done got busy=%b after %0d cycles exp 0", fetch_busy, n);
        end
    endtask

`ifndef VGA_FB_ARB_WR_SLOT_EN
    task automatic test_wr_stall();
        for (int c = 0; c <= 103; c++) begin
            @(negedge clk);
            line_req = (c == 0);
            line_num = 9'd5;
            wr_req   = (c >= 3 && c <= 101);
            wr_addr  = 16'h1234;
            wr_data  = 24'hBEEF01;
            #1;
            if (c >= 3 && c <= 100) begin
                checks++;
                if ({wr_gnt, mem_we, mem_re} !== 3'b001) begin
                    errs++;
                    $display("FAIL stall c=%0d got gnt=%b we=%b re=%b exp 0 0 1",
                             c, wr_gnt, mem_we, mem_re);
                end
            end
            if (c == 101) begin
                checks++;
                if ({wr_gnt, mem_we, mem_re, mem_addr, mem_wdata} !==
                    {1'b1, 1'b1, 1'b0, 16'h1234, 24'hBEEF01}) begin
                    errs++;
                    $display("FAIL stall_gnt got gnt=%b we=%b re=%b addr=%h wd=%h exp 1 1 0 1234 beef01",
                             wr_gnt, mem_we, mem_re, mem_addr, mem_wdata);
                end
            end
            if (c == 102) begin
                checks++;
                if ({wr_gnt, mem_we} !== 2'b00) begin
                    errs++;
                    $display("FAIL stall_end got gnt=%b we=%b exp 0 0", wr_gnt, mem_we);
                end
            end
        end
        wr_req = 1'b0;
    endtask
`else
    task automatic test_wr_slot();
        int          n, done_c;
        logic        nlv;
        logic [6:0]  nli;
        @(negedge clk);
        line_req = 1'b1;
        line_num = 9'd6;
        wr_req   = 1'b1;
        wr_addr  = 16'h0777;
        wr_data  = 24'h00C0DE;
        #1;
        checks++;
        if (wr_gnt !== 1'b1) begin
            errs++;
            $display("FAIL slot_start got gnt=%b exp 1", wr_gnt);
        end
        n      = 0;
        done_c = -1;
        nlv    = 1'b0;
        nli    = 7'h0;
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            line_req = 1'b0;
            #1;
            checks++;
            if ({lb_we, lb_addr} !== {nlv, nli}) begin
                errs++;
                $display("FAIL slot_lb c=%0d got we=%b a=%0d exp we=%b a=%0d",
                         c, lb_we, lb_addr, nlv, nli);
            end
            nlv = 1'b0;
            nli = 7'h0;
            if (n < 100) begin
                checks++;
                if ((c - 1) % 8 == 7) begin
                    if ({mem_re, wr_gnt, mem_addr} !== {1'b0, 1'b1, 16'h0777}) begin
                        errs++;
                        $display("FAIL slot_gnt c=%0d got re=%b gnt=%b addr=%h exp 0 1 0777",
                                 c, mem_re, wr_gnt, mem_addr);
                    end
                end else begin
                    if ({mem_re, wr_gnt, mem_addr} !== {1'b1, 1'b0, 16'd600 + 16'(n)}) begin
                        errs++;
                        $display("FAIL slot_rd c=%0d got re=%b gnt=%b addr=%0d exp 1 0 %0d",
                                 c, mem_re, wr_gnt, mem_addr, 600 + n);
                    end
                    nlv = 1'b1;
                    nli = 7'(n);
                    n++;
                end
            end else if (!fetch_busy && done_c < 0) begin
                done_c = c;
            end
        end
        wr_req = 1'b0;
        checks++;
        if (done_c < 0 || done_c > 117) begin
            errs++;
            $display("FAIL slot_time got %0d cycles exp <= 117", done_c);
        end
    endtask
`endif

    task automatic test_underrun();
        logic [15:0] ea;
        logic        er, el;
        logic [6:0]  ei;
        logic [23:0] ed;
        int          d;
        for (int c = 0; c <= 153; c++) begin
            @(negedge clk);
            line_req     = (c == 0) || (c == 50);
            line_num     = (c < 50) ? 9'd2 : 9'd10;
            underrun_clr = (c == 50);
            #1;
            if (c == 49) begin
                checks++;
                if (underrun !== 1'b0) begin
                    errs++;
                    $display("FAIL ur_before got %b exp 0", underrun);
                end
            end
            if (c == 51) begin
                checks++;
                if (underrun !== 1'b1) begin
                    errs++;
                    $display("FAIL ur_set got %b exp 1", underrun);
                end
            end
            if (c >= 51) begin
                d  = c - 50;
                er = (d <= 100);
                ea = er ? 16'd1000 + 16'(d - 1) : 16'h0;
                el = (d >= 2 && d <= 101);
                ei = el ? 7'(d - 2) : 7'h0;
                ed = el ? pat(16'd1000 + 16'(d - 2)) : 24'h0;
                checks++;
                if ({mem_re, mem_addr, lb_we, lb_addr, lb_data} !==
                    {er, ea, el, ei, ed}) begin
                    errs++;
                    $display("FAIL ur_refetch d=%0d got re=%b addr=%0d lbwe=%b lba=%0d lbd=%h exp re=%b addr=%0d lbwe=%b lba=%0d lbd=%h",
                             d, mem_re, mem_addr, lb_we, lb_addr, lb_data, er, ea, el, ei, ed);
                end
            end
        end
        line_req = 1'b0;
        @(negedge clk);
        underrun_clr = 1'b1;
        #1;
        checks++;
        if (underrun !== 1'b1) begin
            errs++;
            $display("FAIL ur_hold got %b exp 1", underrun);
        end
        @(negedge clk);
        underrun_clr = 1'b0;
        #1;
        checks++;
        if (underrun !== 1'b0) begin
            errs++;
            $display("FAIL ur_clr got %b exp 0", underrun);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            line_req = (c == 0);
            line_num = 9'd4;
            RESET    = (c == 20);
            #1;
            if (c == 19) begin
                checks++;
                if ({mem_re, mem_addr, fetch_busy} !== {1'b1, 16'd418, 1'b1}) begin
                    errs++;
                    $display("FAIL rmid_pre got re=%b addr=%0d busy=%b exp 1 418 1",
                             mem_re, mem_addr, fetch_busy);
                end
            end
            if (c >= 21) begin
                checks++;
                if ({wr_gnt, mem_addr, mem_wdata, mem_we, mem_re, lb_we, lb_addr,
                     lb_data, fetch_busy, underrun} !== '0) begin
                    errs++;
                    $display("FAIL rmid c=%0d got re=%b addr=%h lbwe=%b lba=%0d lbd=%h busy=%b exp all 0",
                             c, mem_re, mem_addr, lb_we, lb_addr, lb_data, fetch_busy);
                end
            end
        end
    endtask

    initial begin
        RESET        = 1'b1;
        line_req     = 1'b0;
        line_num     = 9'd0;
        wr_req       = 1'b0;
        wr_addr      = 16'h0;
        wr_data      = 24'h0;
        underrun_clr = 1'b0;
        test_reset();
        test_fetch(9'd3);
        test_fetch(9'd479);
        test_bad_line();
        test_same_cycle();
`ifndef VGA_FB_ARB_WR_SLOT_EN
        test_wr_stall();
`else
        test_wr_slot();
`endif
        test_underrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
